// File: rtl/serial_negate_unit.sv
// Multi-cycle pass / ones-complement / negate / abs unit working CHUNK bits per clock.
// A registered carry links consecutive chunks; valid/ready on both the operand and result ports.
module serial_negate_unit #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_ovf,
    output logic             out_zero
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0]    LAST_CHUNK = CW'(NCHUNK - 1);
    localparam logic [WIDTH-1:0] MIN_VAL    = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [1:0]       mode_q, mode_d;
    logic             sign_q, sign_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    int unsigned      base;
    logic [CHUNK-1:0] chunk_x;
    logic [CHUNK-1:0] chunk_r;
    logic [CHUNK:0]   chunk_sum;
    logic             do_neg;
    logic [WIDTH-1:0] res_next;

    // NOTE: every combinational output gets a default first, so no path through the case infers a latch.
    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        mode_d     = mode_q;
        sign_d     = sign_q;
        cnt_d      = cnt_q;
        carry_d    = carry_q;
        res_d      = res_q;
        out_data_d = out_data_q;
        ovf_d      = ovf_q;
        zero_d     = zero_q;
        in_ready   = 1'b0;
        out_valid  = 1'b0;

        base      = int'(cnt_q) * CHUNK;
        chunk_x   = x_q[base +: CHUNK];
        chunk_sum = {1'b0, ~chunk_x} + {{CHUNK{1'b0}}, carry_q};
        do_neg    = (mode_q == 2'b10) || ((mode_q == 2'b11) && sign_q);
        if (do_neg)                chunk_r = chunk_sum[CHUNK-1:0];
        else if (mode_q == 2'b01)  chunk_r = ~chunk_x;
        else                       chunk_r = chunk_x;
        res_next = res_q;
        res_next[base +: CHUNK] = chunk_r;

        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    x_d     = in_data;
                    mode_d  = in_mode;
                    sign_d  = in_data[WIDTH-1];
                    cnt_d   = '0;
                    carry_d = 1'b1;  // the +1 of ~x+1 enters as carry into chunk 0
                    state_d = RUN;
                end
            end
            RUN: begin
                res_d   = res_next;
                carry_d = chunk_sum[CHUNK];
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST_CHUNK) begin
                    out_data_d = res_next;
                    ovf_d      = mode_q[1] && (x_q == MIN_VAL);
                    zero_d     = (res_next == '0);
                    state_d    = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; all registers reset so an abandoned operand leaves no trace.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            x_q        <= '0;
            mode_q     <= '0;
            sign_q     <= 1'b0;
            cnt_q      <= '0;
            carry_q    <= 1'b0;
            res_q      <= '0;
            out_data_q <= '0;
            ovf_q      <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            mode_q     <= mode_d;
            sign_q     <= sign_d;
            cnt_q      <= cnt_d;
            carry_q    <= carry_d;
            res_q      <= res_d;
            out_data_q <= out_data_d;
            ovf_q      <= ovf_d;
            zero_q     <= zero_d;
        end
    end

    assign out_data = out_data_q;
    assign out_ovf  = ovf_q;
    assign out_zero = zero_q;

endmodule

// File: tb/tb_serial_negate_unit.sv
// Directed bench for serial_negate_unit: instance 0 uses CHUNK=8, the others CHUNK=1/4/32 for the sweep.
module tb_serial_negate_unit;

    localparam int NI = 4;

    function automatic int chunk_of(input int i);
        case (i)
            0:       return 8;
            1:       return 1;
            2:       return 4;
            default: return 32;
        endcase
    endfunction

    logic        clk;
    logic        rst_n;
    logic        in_valid  [NI];
    logic        in_ready  [NI];
    logic [31:0] in_data   [NI];
    logic [1:0]  in_mode   [NI];
    logic        out_valid [NI];
    logic        out_ready [NI];
    logic [31:0] out_data  [NI];
    logic        out_ovf   [NI];
    logic        out_zero  [NI];

    int n_cmp = 0;
    int n_bad = 0;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        serial_negate_unit #(.WIDTH(32), .CHUNK(chunk_of(g))) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_data   (in_data[g]),
            .in_mode   (in_mode[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out_data  (out_data[g]),
            .out_ovf   (out_ovf[g]),
            .out_zero  (out_zero[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [31:0] x, input logic [1:0] m);
        case (m)
            2'b00:   return x;
            2'b01:   return ~x;
            2'b10:   return 32'd0 - x;
            default: return x[31] ? 32'd0 - x : x;
        endcase
    endfunction

    // Send one operand, wait for the result and optionally complete the output handshake.
    task automatic do_op(input int i, input logic [31:0] x, input logic [1:0] m, input bit release_out,
                         output logic [31:0] d, output logic ovf, output logic zero, output int lat);
        int w;
        @(negedge clk);
        w = 0;
        while (!in_ready[i] && w < 50) begin
            @(negedge clk);
            w++;
        end
        in_valid[i] = 1'b1;
        in_data[i]  = x;
        in_mode[i]  = m;
        @(posedge clk);
        #1;
        in_valid[i] = 1'b0;
        lat = 0;
        while (!out_valid[i] && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        n_cmp++;
        if (out_valid[i] !== 1'b1) begin
            n_bad++;
            $display("FAIL timeout inst%0d x=%h: out_valid=%b required 1", i, x, out_valid[i]);
        end
        d    = out_data[i];
        ovf  = out_ovf[i];
        zero = out_zero[i];
        if (release_out) begin
            @(negedge clk);
            out_ready[i] = 1'b1;
            @(posedge clk);
            #1;
            out_ready[i] = 1'b0;
        end
    endtask

    // Full check of one transaction on instance 0 against hand-computed values.
    task automatic run_vec(input string name, input logic [31:0] x, input logic [1:0] m,
                           input logic [31:0] exp_d, input logic exp_ovf, input logic exp_zero);
        logic [31:0] d;
        logic        ovf, zero;
        int          lat;
        do_op(0, x, m, 1'b1, d, ovf, zero, lat);
        n_cmp++;
        if (d !== exp_d) begin
            n_bad++;
            $display("FAIL %s data: got %h required %h", name, d, exp_d);
        end
        n_cmp++;
        if (ovf !== exp_ovf || zero !== exp_zero) begin
            n_bad++;
            $display("FAIL %s flags: got ovf=%b zero=%b required ovf=%b zero=%b", name, ovf, zero, exp_ovf, exp_zero);
        end
        n_cmp++;
        if (lat !== 4) begin
            n_bad++;
            $display("FAIL %s latency: got %0d required 4", name, lat);
        end
    endtask

    task automatic test_reset;
        for (int i = 0; i < NI; i++) begin
            n_cmp++;
            if (in_ready[i] !== 1'b1 || out_valid[i] !== 1'b0 || out_data[i] !== 32'h0 ||
                out_ovf[i] !== 1'b0 || out_zero[i] !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_state inst%0d: rdy=%b vld=%b data=%h ovf=%b zero=%b required 1 0 0 0 0",
                         i, in_ready[i], out_valid[i], out_data[i], out_ovf[i], out_zero[i]);
            end
        end
    endtask

    task automatic test_negate;
        run_vec("negate_5", 32'h0000_0005, 2'b10, 32'hFFFF_FFFB, 1'b0, 1'b0);
    endtask

    task automatic test_carry;
        run_vec("carry_100", 32'h0000_0100, 2'b10, 32'hFFFF_FF00, 1'b0, 1'b0);
        run_vec("negate_0",  32'h0000_0000, 2'b10, 32'h0000_0000, 1'b0, 1'b1);
    endtask

    task automatic test_abs;
        run_vec("abs_neg7", 32'hFFFF_FFF9, 2'b11, 32'h0000_0007, 1'b0, 1'b0);
        run_vec("abs_pos7", 32'h0000_0007, 2'b11, 32'h0000_0007, 1'b0, 1'b0);
        run_vec("abs_min",  32'h8000_0000, 2'b11, 32'h8000_0000, 1'b1, 1'b0);
        run_vec("neg_min",  32'h8000_0000, 2'b10, 32'h8000_0000, 1'b1, 1'b0);
    endtask

    task automatic test_pass_ones;
        run_vec("pass", 32'hA5A5_0F0F, 2'b00, 32'hA5A5_0F0F, 1'b0, 1'b0);
        run_vec("ones", 32'hA5A5_0F0F, 2'b01, 32'h5A5A_F0F0, 1'b0, 1'b0);
        run_vec("ones_allone", 32'hFFFF_FFFF, 2'b01, 32'h0000_0000, 1'b0, 1'b1);
    endtask

    task automatic test_back_to_back;
        run_vec("b2b_a", 32'h0000_0001, 2'b10, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_vec("b2b_b", 32'h1234_5678, 2'b10, 32'hEDCB_A988, 1'b0, 1'b0);
    endtask

    task automatic test_backpressure;
        logic [31:0] d;
        logic        ovf, zero;
        int          lat;
        bit          stable;
        do_op(0, 32'h0000_0005, 2'b10, 1'b0, d, ovf, zero, lat);
        stable = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            if (out_valid[0] !== 1'b1 || out_data[0] !== 32'hFFFF_FFFB || in_ready[0] !== 1'b0)
                stable = 1'b0;
        end
        n_cmp++;
        if (stable !== 1'b1) begin
            n_bad++;
            $display("FAIL backpressure_hold: vld=%b data=%h rdy=%b required 1 fffffffb 0",
                     out_valid[0], out_data[0], in_ready[0]);
        end
        @(negedge clk);
        out_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        out_ready[0] = 1'b0;
        n_cmp++;
        if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL backpressure_release: rdy=%b vld=%b required 1 0", in_ready[0], out_valid[0]);
        end
    endtask

    task automatic test_reset_mid_run;
        bit stale;
        @(negedge clk);
        in_valid[0] = 1'b1;
        in_data[0]  = 32'h0000_0003;
        in_mode[0]  = 2'b10;
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0 || out_data[0] !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_mid_run: rdy=%b vld=%b data=%h required 1 0 00000000",
                     in_ready[0], out_valid[0], out_data[0]);
        end
        rst_n = 1'b1;
        stale = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            if (out_valid[0] !== 1'b0) stale = 1'b1;
        end
        n_cmp++;
        if (stale !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_stale_result: out_valid rose=%b required 0", stale);
        end
        run_vec("after_reset", 32'h0000_0002, 2'b10, 32'hFFFF_FFFE, 1'b0, 1'b0);
    endtask

    task automatic test_sweep;
        logic [31:0] x, d, exp_d;
        logic        ovf, zero;
        int          lat;
        for (int i = 0; i < NI; i++) begin
            for (int j = 0; j < 8; j++) begin
                case (j)
                    0:       x = 32'h0000_0000;
                    1:       x = 32'h8000_0000;
                    2:       x = 32'hFFFF_FFFF;
                    default: x = $urandom;
                endcase
                exp_d = 32'd0 - x;
                do_op(i, x, 2'b10, 1'b1, d, ovf, zero, lat);
                n_cmp++;
                if (d !== exp_d || ovf !== (x == 32'h8000_0000) || zero !== (exp_d == 32'h0)) begin
                    n_bad++;
                    $display("FAIL sweep chunk=%0d x=%h: got %h ovf=%b zero=%b required %h",
                             chunk_of(i), x, d, ovf, zero, exp_d);
                end
                n_cmp++;
                if (lat !== 32 / chunk_of(i)) begin
                    n_bad++;
                    $display("FAIL sweep_latency chunk=%0d: got %0d required %0d", chunk_of(i), lat, 32 / chunk_of(i));
                end
            end
            x = $urandom;
            do_op(i, x, 2'b11, 1'b1, d, ovf, zero, lat);
            n_cmp++;
            if (d !== model(x, 2'b11)) begin
                n_bad++;
                $display("FAIL sweep_abs chunk=%0d x=%h: got %h required %h", chunk_of(i), x, d, model(x, 2'b11));
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < NI; i++) begin
            in_valid[i]  = 1'b0;
            in_data[i]   = '0;
            in_mode[i]   = '0;
            out_ready[i] = 1'b0;
        end
        #22;
        test_reset;
        @(negedge clk);
        rst_n = 1'b1;
        test_negate;
        test_carry;
        test_abs;
        test_pass_ones;
        test_back_to_back;
        test_backpressure;
        test_reset_mid_run;
        test_sweep;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
